// File: rtl/imem_pkg.sv
// Shared definitions for the pipelined instruction memory: FSM states,
// the default fill word and a constant-foldable log2 helper.
package imem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/imem_valid_pipe.sv
// Delay line carrying {valid, error} and the registered array read data from
// the accept edge to the output stage; flush drops every older entry.
module imem_valid_pipe #(
  parameter int LATENCY = 1,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic         in_error,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         out_error,
  output logic [W-1:0] out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] error_q;

  // Stage 0 always takes the new fetch, so a same-cycle fetch survives a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1] && !flush;
      end
    end
  end

  always_ff @(posedge clk) begin
    error_q[0] <= in_error;
    for (int i = 1; i < LATENCY; i++) begin
      error_q[i] <= error_q[i-1];
    end
  end

  // in_data is already registered at the array output and lines up with stage 0.
  generate
    if (LATENCY > 1) begin : g_delay
      logic [W-1:0] data_q [LATENCY-1];
      always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int i = 1; i < LATENCY - 1; i++) begin
          data_q[i] <= data_q[i-1];
        end
      end
      assign out_data = data_q[LATENCY-2];
    end else begin : g_direct
      assign out_data = in_data;
    end
  endgenerate

  assign out_valid = valid_q[LATENCY-1];
  assign out_error = error_q[LATENCY-1];

endmodule

// File: rtl/imem_pipelined.sv
// Writable, fully pipelined instruction memory with a program-load port,
// fetch flush and a fill sweep that runs after reset or on clear_req.
module imem_pipelined
  import imem_pkg::*;
#(
  parameter int          DEPTH        = 256,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] FILL_INSTR   = NOP,
  localparam int         IDX_W        = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_addr,
  output logic             fetch_ready,
  input  logic             flush,
  output logic             instr_valid,
  output logic [31:0]      instruction,
  output logic             addr_error,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_addr,
  input  logic [31:0]      prog_data,
  input  logic             clear_req,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;

  logic [31:0]      mem [DEPTH];
  logic [31:0]      rd_q;
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_err;
  logic             accept;

  logic             pipe_valid;
  logic             pipe_error;
  logic [31:0]      pipe_data;
  logic [31:0]      held_instr;
  logic             held_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    busy        = 1'b1;
    fetch_ready = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy        = 1'b0;
        fetch_ready = 1'b1;
        if (clear_req) begin
          state_d     = ST_CLEAR;
          sweep_idx_d = '0;
        end
      end
      default: begin
        state_d     = ST_CLEAR;
        sweep_idx_d = '0;
      end
    endcase
  end

  // Handshake: a fetch is taken on any edge where fetch_req && fetch_ready;
  // its result is presented exactly READ_LATENCY cycles later with instr_valid
  // high for one cycle, with no back-pressure on the result side.
  assign accept    = fetch_req && fetch_ready;
  assign fetch_idx = fetch_addr[IDX_W+1:2];
  assign fetch_err = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:IDX_W+2] != '0);

  // The sweep owns the single write port; prog_we is dropped while it runs.
  // The read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[sweep_idx_q] <= FILL_INSTR;
    end else if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
    rd_q <= mem[fetch_idx];
  end

  imem_valid_pipe #(
    .LATENCY (READ_LATENCY),
    .W       (32)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (accept),
    .in_error  (fetch_err),
    .in_data   (rd_q),
    .out_valid (pipe_valid),
    .out_error (pipe_error),
    .out_data  (pipe_data)
  );

  // A result reaching the output during a flush belongs to an older fetch.
  assign instr_valid = pipe_valid && !flush;
  assign instruction = instr_valid ? (pipe_error ? FILL_INSTR : pipe_data) : held_instr;
  assign addr_error  = instr_valid ? pipe_error : held_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      held_instr <= FILL_INSTR;
      held_error <= 1'b0;
    end else begin
      held_instr <= instruction;
      held_error <= addr_error;
    end
  end

endmodule
